fetch_unit: RTL and testbench

//  Instruction fetch stage; producer side of the IF/ID interface whose consumer is the decode circuit.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC ownership, imem fetch, IF/ID register, interrupt injection
module fetch_unit #(
  parameter int                      ADDR_WIDTH    = 10,
  parameter int                      INSTR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0]   RST_VEC_ADDR  = 10'h000,
  parameter logic [ADDR_WIDTH-1:0]   INTR_VEC_ADDR = 10'h001,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR     = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]  INTR_INSTR    = 16'hC0C0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Stall,
  input  logic                   Branch_Taken,
  input  logic [ADDR_WIDTH-1:0]  Branch_Addr,
  input  logic                   Intr_Req,
  input  logic                   Intr_Ack,
  output logic [ADDR_WIDTH-1:0]  Imem_Addr,
  input  logic [INSTR_WIDTH-1:0] Imem_Data,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   Instr_Valid,
  output logic [ADDR_WIDTH-1:0]  Saved_PC,
  output logic                   Intr_Pending
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_saved_pc;
  logic                   r_pending;
  logic                   w_inject;
  logic [ADDR_WIDTH-1:0]  w_pc_inc;
  logic [ADDR_WIDTH-1:0]  w_mem_addr;

  // Injection happens only in RUN when neither a branch nor a stall outranks it.
  assign w_inject   = (r_state == S_RUN) && !Branch_Taken && !Stall && r_pending;
  assign w_pc_inc   = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_mem_addr = Imem_Data[ADDR_WIDTH-1:0];

  always_comb begin
    Imem_Addr = r_pc;
    case (r_state)
      S_BOOT:     Imem_Addr = RST_VEC_ADDR;
      S_WAIT_ACK: Imem_Addr = INTR_VEC_ADDR;
      default:    Imem_Addr = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= '0;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_saved_pc <= '0;
      r_pending  <= 1'b0;
    end else begin
      // A request arriving on the injection edge stays latched for the next one.
      if (Intr_Req)
        r_pending <= 1'b1;
      else if (w_inject)
        r_pending <= 1'b0;

      case (r_state)
        S_BOOT: begin
          r_pc    <= w_mem_addr;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (Branch_Taken) begin
            r_pc    <= Branch_Addr;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (Stall) begin
            r_pc    <= r_pc;
          end else if (r_pending) begin
            r_instr    <= INTR_INSTR;
            r_valid    <= 1'b1;
            r_saved_pc <= r_pc;
            r_state    <= S_WAIT_ACK;
          end else begin
            r_instr <= Imem_Data;
            r_valid <= 1'b1;
            r_pc    <= w_pc_inc;
          end
        end
        S_WAIT_ACK: begin
          if (Intr_Ack && !Stall) begin
            r_pc    <= w_mem_addr;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_state <= S_RUN;
          end else if (!Stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Instr        = r_instr;
  assign Instr_Valid  = r_valid;
  assign Saved_PC     = r_saved_pc;
  assign Intr_Pending = r_pending;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed vectors
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Branch_Taken;
  logic [9:0]  Branch_Addr;
  logic        Intr_Req;
  logic        Intr_Ack;
  logic [9:0]  Imem_Addr;
  logic [15:0] Imem_Data;
  logic [15:0] Instr;
  logic        Instr_Valid;
  logic [9:0]  Saved_PC;
  logic        Intr_Pending;

  logic [15:0] mem [1024];
  logic [15:0] exp_q [$];
  logic [9:0]  pc_m;
  logic        stall_at_edge;
  logic        rst_at_edge;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .Stall        (Stall),
    .Branch_Taken (Branch_Taken),
    .Branch_Addr  (Branch_Addr),
    .Intr_Req     (Intr_Req),
    .Intr_Ack     (Intr_Ack),
    .Imem_Addr    (Imem_Addr),
    .Imem_Data    (Imem_Data),
    .Instr        (Instr),
    .Instr_Valid  (Instr_Valid),
    .Saved_PC     (Saved_PC),
    .Intr_Pending (Intr_Pending)
  );

  always #5 clk = ~clk;
  assign Imem_Data = mem[Imem_Addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Each call issues one ordinary fetch and predicts the word it delivers.
  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[pc_m]);
      pc_m = pc_m + 10'd1;
      tick();
    end
  endtask

  always @(posedge clk) begin
    stall_at_edge = Stall;
    rst_at_edge   = rst;
  end

  // Monitor: a fresh IF/ID word is presented after any non-stalled, non-reset edge with Valid=1.
  always @(negedge clk) begin
    if (Instr_Valid === 1'b1 && stall_at_edge === 1'b0 && rst_at_edge === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%0h expected no instruction", Instr);
      end else begin
        check("sb_instr", {16'h0, Instr}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h8000 + 16'(i);
    mem[0] = 16'h0020;
    mem[1] = 16'h0200;
    rst = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Addr = '0;
    Intr_Req = 1'b0; Intr_Ack = 1'b0;
    tick(); tick();
    check("rst_instr",   {16'h0, Instr}, 32'h0);
    check("rst_valid",   {31'h0, Instr_Valid}, 32'h0);
    check("rst_saved",   {22'h0, Saved_PC}, 32'h0);
    check("rst_pending", {31'h0, Intr_Pending}, 32'h0);
    rst = 1'b0;
    check("boot_addr", {22'h0, Imem_Addr}, 32'h000);

    // 1. boot through reset vector, fetch 0x020..0x023
    tick();
    check("boot_pc", {22'h0, Imem_Addr}, 32'h020);
    check("boot_valid", {31'h0, Instr_Valid}, 32'h0);
    pc_m = 10'h020;
    fetch_n(4);

    // 2. stall three cycles at PC=0x024
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", {16'h0, Instr}, 32'h8023);
      check("stall_valid", {31'h0, Instr_Valid}, 32'h1);
      check("stall_pc",    {22'h0, Imem_Addr}, 32'h024);
    end
    Stall = 1'b0;
    fetch_n(2);

    // 3. branch wins over stall
    Branch_Taken = 1'b1; Branch_Addr = 10'h155; Stall = 1'b1;
    tick();
    check("br_instr", {16'h0, Instr}, 32'h0);
    check("br_valid", {31'h0, Instr_Valid}, 32'h0);
    check("br_pc",    {22'h0, Imem_Addr}, 32'h155);
    Branch_Taken = 1'b0; Stall = 1'b0;
    pc_m = 10'h155;
    fetch_n(2);

    // 4. interrupt latched on the branch edge to 0x030, injected next edge
    Branch_Taken = 1'b1; Branch_Addr = 10'h030; Intr_Req = 1'b1;
    tick();
    check("irq_pending_set", {31'h0, Intr_Pending}, 32'h1);
    Branch_Taken = 1'b0; Intr_Req = 1'b0;
    pc_m = 10'h030;
    exp_q.push_back(16'hC0C0);
    tick();
    check("irq_saved",   {22'h0, Saved_PC}, 32'h030);
    check("irq_pending_clr", {31'h0, Intr_Pending}, 32'h0);
    check("irq_vec_addr", {22'h0, Imem_Addr}, 32'h001);
    Branch_Taken = 1'b1; Branch_Addr = 10'h155;
    tick();
    check("wait_valid", {31'h0, Instr_Valid}, 32'h0);
    check("wait_instr", {16'h0, Instr}, 32'h0);
    check("wait_br_ignored", {22'h0, Imem_Addr}, 32'h001);
    Branch_Taken = 1'b0; Intr_Ack = 1'b1;
    tick();
    Intr_Ack = 1'b0;
    check("ack_isr_pc", {22'h0, Imem_Addr}, 32'h200);
    check("ack_valid",  {31'h0, Instr_Valid}, 32'h0);
    pc_m = 10'h200;
    fetch_n(2);

    // 5. PC wrap 0x3FF -> 0x000
    Branch_Taken = 1'b1; Branch_Addr = 10'h3FE;
    tick();
    Branch_Taken = 1'b0;
    pc_m = 10'h3FE;
    fetch_n(3);
    check("wrap_pc", {22'h0, Imem_Addr}, 32'h001);

    // 6. reset while waiting for ack discards a newly latched request
    exp_q.push_back(mem[pc_m]);
    Intr_Req = 1'b1;
    tick();
    pc_m = pc_m + 10'd1;
    Intr_Req = 1'b0;
    exp_q.push_back(16'hC0C0);
    tick();
    check("w6_saved", {22'h0, Saved_PC}, 32'h002);
    Intr_Req = 1'b1;
    tick();
    Intr_Req = 1'b0;
    check("w6_pending", {31'h0, Intr_Pending}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r6_pending", {31'h0, Intr_Pending}, 32'h0);
    check("r6_valid",   {31'h0, Instr_Valid}, 32'h0);
    check("r6_saved",   {22'h0, Saved_PC}, 32'h0);
    check("r6_boot",    {22'h0, Imem_Addr}, 32'h000);
    tick();
    check("r6_reboot", {22'h0, Imem_Addr}, 32'h020);
    pc_m = 10'h020;
    fetch_n(2);
    Stall = 1'b1;
    tick(); tick();
    check("sb_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
